// File: rtl/calculator_input_ctrl.sv
// Keypad and sequencing controller for the 6x4 on-screen calculator.
// Turns button pulses into cursor moves and key presses, builds operands and
// hands op1/op2/op to the ALU over a valid/ready handshake.
// Build option: define CALC_DEC_MODE_EN to enable decimal entry (mode=0);
// without it the mode port is ignored and entry is hex only.
module calculator_input_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned GRID_W     = 6,
  parameter int unsigned GRID_H     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        mode,
  input  logic        alu_ready,
  input  logic [15:0] alu_result,
  output logic [2:0]  pos_x,
  output logic [1:0]  pos_y,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [2:0]  op,
  output logic [15:0] input_screen,
  output logic        alu_valid,
  output logic        busy
);

  localparam logic [2:0] XMax   = 3'(GRID_W - 1);
  localparam logic [1:0] YMax   = 2'(GRID_H - 1);
  localparam logic [2:0] MaxCnt = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {StEnterOp1, StEnterOp2, StWaitAlu, StShowResult} state_e;

  state_e      state;
  logic [15:0] entry;
  logic [2:0]  count;

  logic        is_digit, is_op, is_ce, is_clr, is_exe;
  logic [3:0]  key_digit;
  logic [2:0]  key_op;
  logic        digit_ok, lead_zero;
  logic [15:0] digit_entry;

  // Decode the key under the cursor from the fixed 6x4 key map
  always_comb begin
    is_digit  = 1'b0;
    is_op     = 1'b0;
    is_ce     = 1'b0;
    is_clr    = 1'b0;
    is_exe    = 1'b0;
    key_digit = 4'd0;
    key_op    = 3'd0;
    if (pos_x <= 3'd5) begin
      unique case (pos_y)
        2'd0: begin
          is_digit  = 1'b1;
          key_digit = 4'(pos_x);
        end
        2'd1: begin
          is_digit  = 1'b1;
          key_digit = 4'd6 + 4'(pos_x);
        end
        2'd2: begin
          if (pos_x < 3'd4) begin
            is_digit  = 1'b1;
            key_digit = 4'd12 + 4'(pos_x);
          end else begin
            is_op  = 1'b1;
            key_op = (pos_x == 3'd4) ? 3'd0 : 3'd1;
          end
        end
        2'd3: begin
          case (pos_x)
            3'd0:    begin is_op = 1'b1; key_op = 3'd2; end
            3'd1:    begin is_op = 1'b1; key_op = 3'd3; end
            3'd2:    begin is_op = 1'b1; key_op = 3'd4; end
            3'd3:    is_ce  = 1'b1;
            3'd4:    is_clr = 1'b1;
            default: is_exe = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Digit acceptance and the entry value a digit press would produce
`ifdef CALC_DEC_MODE_EN
  always_comb begin
    digit_ok    = is_digit && (mode || key_digit <= 4'd9);
    digit_entry = mode ? {entry[11:0], key_digit}
                       : (entry << 3) + (entry << 1) + 16'(key_digit);
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  always_comb begin
    digit_ok    = is_digit;
    digit_entry = {entry[11:0], key_digit};
  end
`endif

  // A zero typed into an empty entry does not consume a digit slot
  assign lead_zero = (entry == 16'd0) && (key_digit == 4'd0);

  // Sequencing FSM, cursor and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StEnterOp1;
      entry        <= '0;
      count        <= '0;
      pos_x        <= '0;
      pos_y        <= '0;
      op1          <= '0;
      op2          <= '0;
      op           <= '0;
      input_screen <= '0;
      alu_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (btn_center) begin
        if (is_clr && state != StWaitAlu) begin
          state        <= StEnterOp1;
          entry        <= '0;
          count        <= '0;
          op1          <= '0;
          op2          <= '0;
          op           <= '0;
          input_screen <= '0;
          alu_valid    <= 1'b0;
          busy         <= 1'b0;
        end else begin
          case (state)
            StEnterOp1, StEnterOp2: begin
              if (digit_ok) begin
                if (count < MaxCnt) begin
                  entry        <= digit_entry;
                  input_screen <= digit_entry;
                  if (!lead_zero) count <= count + 3'd1;
                end
              end else if (is_op) begin
                op <= key_op;
                if (state == StEnterOp1) begin
                  op1          <= entry;
                  entry        <= '0;
                  count        <= '0;
                  input_screen <= '0;
                  state        <= StEnterOp2;
                end
              end else if (is_ce) begin
                entry        <= '0;
                count        <= '0;
                input_screen <= '0;
              end else if (is_exe && state == StEnterOp2) begin
                op2       <= entry;
                alu_valid <= 1'b1;
                busy      <= 1'b1;
                state     <= StWaitAlu;
              end
            end
            StShowResult: begin
              if (digit_ok) begin
                entry        <= 16'(key_digit);
                count        <= 3'd1;
                input_screen <= 16'(key_digit);
                state        <= StEnterOp1;
              end else if (is_op) begin
                op1          <= input_screen;
                op           <= key_op;
                entry        <= '0;
                count        <= '0;
                input_screen <= '0;
                state        <= StEnterOp2;
              end
            end
            default: ;
          endcase
        end
      end else if (btn_up) begin
        pos_y <= (pos_y == 2'd0) ? YMax : pos_y - 2'd1;
      end else if (btn_down) begin
        pos_y <= (pos_y == YMax) ? 2'd0 : pos_y + 2'd1;
      end else if (btn_left) begin
        pos_x <= (pos_x == 3'd0) ? XMax : pos_x - 3'd1;
      end else if (btn_right) begin
        pos_x <= (pos_x == XMax) ? 3'd0 : pos_x + 3'd1;
      end

      // ALU handshake; buttons never touch these registers in StWaitAlu
      if (state == StWaitAlu && alu_valid && alu_ready) begin
        input_screen <= alu_result;
        alu_valid    <= 1'b0;
        busy         <= 1'b0;
        state        <= StShowResult;
      end
    end
  end

endmodule

// File: tb/tb_calculator_input_ctrl.sv
// Directed bench for calculator_input_ctrl; expected values are hand-computed.
module tb_calculator_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_center = 1'b0;
  logic        mode = 1'b1;
  logic        alu_ready = 1'b0;
  logic [15:0] alu_result = '0;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic [15:0] op1, op2, input_screen;
  logic [2:0]  op;
  logic        alu_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cx = 0;
  int cy = 0;

  calculator_input_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_center   (btn_center),
    .mode         (mode),
    .alu_ready    (alu_ready),
    .alu_result   (alu_result),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .op1          (op1),
    .op2          (op2),
    .op           (op),
    .input_screen (input_screen),
    .alu_valid    (alu_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle button pulse; outputs are sampled 1 time unit after the edge
  task automatic pulse(input logic u, input logic d, input logic l, input logic r,
                       input logic c);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_center = c;
    @(posedge clk); #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_center = 0;
  endtask

  // Move cursor using right/down only; bench tracks position in cx/cy
  task automatic goto(input int x, input int y);
    for (int i = 0; i < 6 && cx != x; i++) begin
      pulse(0, 0, 0, 1, 0);
      cx = (cx + 1) % 6;
    end
    for (int i = 0; i < 4 && cy != y; i++) begin
      pulse(0, 1, 0, 0, 0);
      cy = (cy + 1) % 4;
    end
  endtask

  task automatic key(input int x, input int y);
    goto(x, y);
    pulse(0, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pos_x", 16'(pos_x), 16'd0);
    check("rst_pos_y", 16'(pos_y), 16'd0);
    check("rst_op1", op1, 16'd0);
    check("rst_op2", op2, 16'd0);
    check("rst_op", 16'(op), 16'd0);
    check("rst_screen", input_screen, 16'd0);
    check("rst_valid", 16'(alu_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst_n = 1'b1;

    // Wrap and priority
    pulse(0, 0, 1, 0, 0);
    check("wrap_left", 16'(pos_x), 16'd5);
    pulse(1, 0, 0, 0, 0);
    check("wrap_up", 16'(pos_y), 16'd3);
    pulse(1, 0, 0, 1, 0);
    check("prio_up_y", 16'(pos_y), 16'd2);
    check("prio_up_x", 16'(pos_x), 16'd5);
    cx = 5; cy = 2;

    // Hex flow: 1 2 + 3 EXE
    mode = 1'b1;
    key(1, 0);
    check("hex_d1", input_screen, 16'h0001);
    key(2, 0);
    check("hex_d2", input_screen, 16'h0012);
    key(4, 2);
    check("plus_op1", op1, 16'h0012);
    check("plus_op", 16'(op), 16'd0);
    check("plus_screen", input_screen, 16'h0000);
    key(3, 0);
    check("hex_d3", input_screen, 16'h0003);
    key(5, 3);
    check("exe_op2", op2, 16'h0003);
    check("exe_valid", 16'(alu_valid), 16'd1);
    check("exe_busy", 16'(busy), 16'd1);

    // Stall with alu_ready low
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 16'(alu_valid), 16'd1);
      check("stall_op1", op1, 16'h0012);
      check("stall_op2", op2, 16'h0003);
    end

    // Keys and CLR ignored while waiting; cursor still moves
    key(4, 3);
    check("wait_clr_valid", 16'(alu_valid), 16'd1);
    check("wait_clr_op1", op1, 16'h0012);
    check("wait_clr_busy", 16'(busy), 16'd1);
    key(5, 0);
    check("wait_digit_screen", input_screen, 16'h0003);
    check("wait_pos_x", 16'(pos_x), 16'd5);

    // Handshake
    alu_ready = 1'b1;
    alu_result = 16'h0015;
    @(posedge clk); #1;
    alu_ready = 1'b0;
    alu_result = 16'h0000;
    check("res_screen", input_screen, 16'h0015);
    check("res_valid", 16'(alu_valid), 16'd0);
    check("res_busy", 16'(busy), 16'd0);

    // Chain with *
    key(0, 3);
    check("chain_op1", op1, 16'h0015);
    check("chain_op", 16'(op), 16'd2);
    check("chain_screen", input_screen, 16'h0000);
    key(4, 0);
    check("chain_d4", input_screen, 16'h0004);
    key(3, 3);
    check("ce_screen", input_screen, 16'h0000);
    key(1, 1);
    check("after_ce_d7", input_screen, 16'h0007);
    key(4, 3);
    check("clr_op1", op1, 16'h0000);
    check("clr_op2", op2, 16'h0000);
    check("clr_op", 16'(op), 16'd0);
    check("clr_screen", input_screen, 16'h0000);
    check("clr_pos_x", 16'(pos_x), 16'd4);
    check("clr_pos_y", 16'(pos_y), 16'd3);

    // Leading zeros and digit limit
    key(0, 0);
    key(0, 0);
    key(1, 0);
    key(2, 0);
    key(3, 0);
    key(4, 0);
    check("four_digits", input_screen, 16'h1234);
    key(5, 0);
    check("fifth_ignored", input_screen, 16'h1234);
    key(5, 3);
    check("exe_op1_ignored", 16'(alu_valid), 16'd0);
    check("exe_op1_screen", input_screen, 16'h1234);
    key(4, 2);
    check("op_plus_op1", op1, 16'h1234);
    key(5, 2);
    check("op2_minus", 16'(op), 16'd1);
    check("op2_minus_op1", op1, 16'h1234);
    key(2, 3);
    check("op2_or", 16'(op), 16'd4);
    key(3, 2);
    check("hex_f", input_screen, 16'h000F);
    key(5, 3);
    check("exe2_op2", op2, 16'h000F);
    check("exe2_valid", 16'(alu_valid), 16'd1);

    // Reset mid-wait
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cx = 0; cy = 0;
    check("midrst_valid", 16'(alu_valid), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_op1", op1, 16'h0000);
    check("midrst_pos_x", 16'(pos_x), 16'd0);

`ifdef CALC_DEC_MODE_EN
    mode = 1'b0;
    for (int i = 0; i < 5; i++) key(3, 1);
    key(4, 1);
    check("dec_9999", input_screen, 16'h270F);
`else
    mode = 1'b0;
    key(4, 1);
    check("hex_only_a", input_screen, 16'h000A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
